// File: rtl/alu_operand_stage_if.sv
// rtl/alu_operand_stage_if.sv - instruction handshake and ALU operand/result bus for alu_operand_stage
interface alu_operand_stage_if #(
    parameter int BITS = 16
);
    logic [15:0]     instr;
    logic            instr_valid;
    logic            instr_ready;
    logic [BITS-1:0] aluOut;
    logic [BITS-1:0] A;
    logic [BITS-1:0] B;
    logic [4:0]      aluOp;
    logic            execute;

    // Upstream fetch plus ALU side: supplies instructions and results, consumes operands
    modport master (
        output instr, instr_valid, aluOut,
        input  instr_ready, A, B, aluOp, execute
    );

    // Operand stage side
    modport slave (
        input  instr, instr_valid, aluOut,
        output instr_ready, A, B, aluOp, execute
    );
endinterface

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - decode/regfile/IMM-prefix issue stage for the 16-bit ALU; ALU_OPERAND_FWD_EN enables wb2 forwarding
module alu_operand_stage #(
    parameter int BITS  = 16,
    parameter int NREGS = 16
) (
    input  logic                 CLK,
    input  logic                 RSTb,
    alu_operand_stage_if.slave   bus,
    input  logic [3:0]           dbg_sel,
    output logic [BITS-1:0]      dbg_data
);

    logic [BITS-1:0] regs_q [NREGS];
    logic [11:0]     imm_hi_q;
    logic            prefix_valid_q;
    logic            wb1_valid_q;
    logic [3:0]      wb1_rd_q;
    logic            wb2_valid_q;
    logic [3:0]      wb2_rd_q;
    logic [BITS-1:0] a_q;
    logic [BITS-1:0] b_q;
    logic [4:0]      aluop_q;
    logic            execute_q;

    logic [3:0]      op;
    logic [3:0]      rd;
    logic [3:0]      rs;
    logic            is_imm;
    logic            is_rr;
    logic            is_ri;
    logic            is_ext;
    logic            is_issue;
    logic            hit1_rd;
    logic            hit1_rs;
    logic            hit2_rd;
    logic            hit2_rs;
    logic            stall;
    logic            accept;
    logic [BITS-1:0] rd_val;
    logic [BITS-1:0] rs_val;
    logic [BITS-1:0] a_d;
    logic [BITS-1:0] b_d;
    logic [4:0]      aluop_d;
    logic            writes_d;

    assign op       = bus.instr[15:12];
    assign rd       = bus.instr[7:4];
    assign rs       = bus.instr[3:0];
    assign is_imm   = (op == 4'h1);
    assign is_rr    = (op == 4'h2);
    assign is_ri    = (op == 4'h3);
    assign is_ext   = (op == 4'h4);
    assign is_issue = is_rr | is_ri | is_ext;

    // A source collides with an in-flight result only if it is a real register
    assign hit1_rd = is_issue && (rd != 4'd0) && wb1_valid_q && (wb1_rd_q == rd);
    assign hit1_rs = is_rr    && (rs != 4'd0) && wb1_valid_q && (wb1_rd_q == rs);
    assign hit2_rd = is_issue && (rd != 4'd0) && wb2_valid_q && (wb2_rd_q == rd);
    assign hit2_rs = is_rr    && (rs != 4'd0) && wb2_valid_q && (wb2_rd_q == rs);

`ifdef ALU_OPERAND_FWD_EN
    // wb2 results are on aluOut this cycle, so only a wb1 match must wait
    assign stall = bus.instr_valid && (hit1_rd || hit1_rs);
`else
    // Without forwarding, wait until the result has landed in the register file
    assign stall = bus.instr_valid && (hit1_rd || hit1_rs || hit2_rd || hit2_rs);
`endif

    assign accept          = bus.instr_valid && !stall;
    assign bus.instr_ready = accept;

    // Register-file read ports with r0 hardwired to zero and optional wb2 bypass
    always_comb begin
        rd_val = (rd == 4'd0) ? '0 : regs_q[rd];
        rs_val = (rs == 4'd0) ? '0 : regs_q[rs];
`ifdef ALU_OPERAND_FWD_EN
        if (hit2_rd) rd_val = bus.aluOut;
        if (hit2_rs) rs_val = bus.aluOut;
`endif
    end

    // Operand and opcode selection for the three issuing formats
    always_comb begin
        a_d     = rd_val;
        b_d     = rs_val;
        aluop_d = {1'b0, bus.instr[11:8]};
        case (op)
            4'h3: begin
                if (prefix_valid_q) b_d = BITS'({imm_hi_q, bus.instr[3:0]});
                else                b_d = BITS'({12'd0, bus.instr[3:0]});
            end
            4'h4: begin
                aluop_d = {1'b1, bus.instr[11:8]};
                b_d     = rd_val;
            end
            default: ;
        endcase
    end

    // Compare, test and other flag-only opcodes produce no register result
    always_comb begin
        writes_d = 1'b1;
        case (aluop_d)
            5'd12, 5'd13, 5'd23, 5'd24, 5'd25, 5'd26,
            5'd27, 5'd28, 5'd30, 5'd31: writes_d = 1'b0;
            default: ;
        endcase
    end

    // Issue registers, prefix state, writeback tracker and register-file write
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            a_q            <= '0;
            b_q            <= '0;
            aluop_q        <= '0;
            execute_q      <= 1'b0;
            imm_hi_q       <= '0;
            prefix_valid_q <= 1'b0;
            wb1_valid_q    <= 1'b0;
            wb1_rd_q       <= '0;
            wb2_valid_q    <= 1'b0;
            wb2_rd_q       <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            wb2_valid_q <= wb1_valid_q;
            wb2_rd_q    <= wb1_rd_q;
            wb1_valid_q <= accept && is_issue && writes_d;
            wb1_rd_q    <= rd;
            execute_q   <= accept && is_issue;
            if (accept && is_issue) begin
                a_q     <= a_d;
                b_q     <= b_d;
                aluop_q <= aluop_d;
            end
            if (accept) begin
                if (is_imm) begin
                    imm_hi_q       <= bus.instr[11:0];
                    prefix_valid_q <= 1'b1;
                end else begin
                    prefix_valid_q <= 1'b0;
                end
            end
            if (wb2_valid_q && (wb2_rd_q != 4'd0)) regs_q[wb2_rd_q] <= bus.aluOut;
        end
    end

    assign bus.A       = a_q;
    assign bus.B       = b_q;
    assign bus.aluOp   = aluop_q;
    assign bus.execute = execute_q;
    assign dbg_data    = regs_q[dbg_sel];

endmodule
